// File: rtl/sm_dbg_dump.sv
// rtl/sm_dbg_dump.sv - streams CPU debug-port registers then data-RAM words out a valid/ready port
// Optional build macro SM_DBG_DUMP_HDR_EN prepends a {16'hD0D0, RAM_CNT, REG_CNT} header word.
module sm_dbg_dump #(
  parameter int REG_CNT = 32,
  parameter int RAM_CNT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic [4:0]  ramAddr,
  input  logic [31:0] ramData,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REG_RD  = 3'd1;
  localparam logic [2:0] RAM_ADR = 3'd2;
  localparam logic [2:0] RAM_CAP = 3'd3;
  localparam logic [2:0] SEND    = 3'd4;
  localparam logic [2:0] FIN     = 3'd5;
`ifdef SM_DBG_DUMP_HDR_EN
  localparam logic [2:0] HDR     = 3'd6;
  localparam logic [1:0] PH_HDR  = 2'd2;
  localparam logic [31:0] HDR_WORD = {16'hD0D0, 8'(RAM_CNT), 8'(REG_CNT)};
`endif

  localparam logic [1:0] PH_REG = 2'd0;
  localparam logic [1:0] PH_RAM = 2'd1;

  // 6-bit limits so a count of 32 compares cleanly against index+1
  localparam logic [5:0] REG_LIM = 6'(REG_CNT);
  localparam logic [5:0] RAM_LIM = 6'(RAM_CNT);

  logic [2:0]  state;
  logic [1:0]  phase;
  logic [4:0]  idx;
  logic [31:0] dataQ;
  logic        lastQ;
  logic [5:0]  idxNext;
  logic        regLastWord;
  logic        ramLastWord;

  assign idxNext     = {1'b0, idx} + 6'd1;
  assign regLastWord = (idxNext == REG_LIM);
  assign ramLastWord = (idxNext == RAM_LIM);

  assign regAddr   = (state == REG_RD)  ? idx : 5'd0;
  assign ramAddr   = (state == RAM_ADR) ? idx : 5'd0;
  assign out_valid = (state == SEND);
  assign out_data  = dataQ;
  assign out_last  = lastQ & (state == SEND);
  assign busy      = (state != IDLE) && (state != FIN);
  assign done      = (state == FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      phase <= PH_REG;
      idx   <= 5'd0;
      dataQ <= 32'd0;
      lastQ <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx <= 5'd0;
`ifdef SM_DBG_DUMP_HDR_EN
            phase <= PH_HDR;
            state <= HDR;
`else
            phase <= PH_REG;
            state <= REG_RD;
`endif
          end
        end
`ifdef SM_DBG_DUMP_HDR_EN
        HDR: begin
          dataQ <= HDR_WORD;
          lastQ <= 1'b0;
          state <= SEND;
        end
`endif
        REG_RD: begin
          dataQ <= regData;
          lastQ <= (RAM_LIM == 6'd0) && regLastWord;
          state <= SEND;
        end
        RAM_ADR: begin
          state <= RAM_CAP;
        end
        RAM_CAP: begin
          // RAM read data arrives one cycle after the address was presented
          dataQ <= ramData;
          lastQ <= ramLastWord;
          state <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            lastQ <= 1'b0;
            case (phase)
              PH_REG: begin
                if (!regLastWord) begin
                  idx   <= idxNext[4:0];
                  state <= REG_RD;
                end else if (RAM_LIM != 6'd0) begin
                  idx   <= 5'd0;
                  phase <= PH_RAM;
                  state <= RAM_ADR;
                end else begin
                  state <= FIN;
                end
              end
              PH_RAM: begin
                if (!ramLastWord) begin
                  idx   <= idxNext[4:0];
                  state <= RAM_ADR;
                end else begin
                  state <= FIN;
                end
              end
              default: begin
                // header word sent; register 0 follows
                phase <= PH_REG;
                state <= REG_RD;
              end
            endcase
          end
        end
        FIN: begin
          idx   <= 5'd0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sm_dbg_dump.md
SM_DBG_DUMP -- requirements
Module: sm_dbg_dump

Interface
REQ-001 SHALL have parameter REG_CNT, default 32, meaning the number of debug-port register words dumped (1..32).
REQ-002 SHALL have parameter RAM_CNT, default 16, meaning the number of data-RAM words dumped (0..32).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle dump request, sampled only in IDLE.
REQ-006 SHALL have port regAddr, output, 5 bits: CPU debug-port register index (index 0 returns PC).
REQ-007 SHALL have port regData, input, 32 bits: combinational debug-port read data, valid in the same cycle as regAddr.
REQ-008 SHALL have port ramAddr, output, 5 bits: data-RAM debug read word address.
REQ-009 SHALL have port ramData, input, 32 bits: RAM read data, valid exactly 1 cycle after ramAddr.
REQ-010 SHALL have port out_valid, output, 1 bit: a stream word is present.
REQ-011 SHALL have port out_ready, input, 1 bit: the sink accepts the word; a transfer occurs when out_valid and out_ready are both high.
REQ-012 SHALL have port out_data, output, 32 bits: the stream word.
REQ-013 SHALL have port out_last, output, 1 bit: high with the final word of a dump.
REQ-014 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until the cycle after the last transfer.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse in the cycle after the last transfer.

Function
REQ-016 SHALL implement the FSM states IDLE, REG_RD, RAM_ADR, RAM_CAP, SEND, and FIN.
REQ-017 SHALL, in IDLE with start=1, clear the word index and go to REG_RD, or to HDR when SM_DBG_DUMP_HDR_EN is defined; start in any other state is ignored.
REQ-018 SHALL, in REG_RD, drive regAddr=index, capture regData into the output register in the same cycle, and go to SEND.
REQ-019 SHALL, in RAM_ADR, drive ramAddr=index and go to RAM_CAP; in RAM_CAP, capture ramData and go to SEND.
REQ-020 SHALL, in SEND, hold out_valid=1 with stable out_data and out_last until out_ready=1; out_valid is never dropped without a transfer.
REQ-021 SHALL, after a transfer, increment the index and proceed as follows: index < REG_CNT -> REG_RD; then index resets to 0 and the FSM goes to RAM_ADR until RAM_CNT words are sent; after the last word -> FIN.
REQ-022 SHALL, when RAM_CNT=0, skip the RAM phase, and out_last SHALL mark the last register word.
REQ-023 SHALL, in FIN, assert done=1 for one cycle, deassert busy, and return to IDLE.
REQ-024 SHALL hold regAddr and ramAddr at 0 outside the REG_RD and RAM_ADR states.
REQ-025 SHALL give each word a minimum latency of 1 cycle (register) or 2 cycles (RAM) from state entry to out_valid.
REQ-026 SHALL wrap the 5-bit index counters modulo 32, but the parameter bounds SHALL prevent overflow.

Reset
REQ-027 SHALL, with rst=1 at a clock edge, enter IDLE and force out_valid=0, out_last=0, out_data=0, busy=0, done=0, regAddr=0, ramAddr=0, and the index to 0.
REQ-028 SHALL, on reset mid-dump, abort the dump with no done pulse, and the next start SHALL begin again at register 0.

Configuration
REQ-029 SHALL, when macro SM_DBG_DUMP_HDR_EN is defined, add state HDR, which emits one word {16'hD0D0, RAM_CNT[7:0], REG_CNT[7:0]} before register 0 under the same handshake.
REQ-030 SHALL, when SM_DBG_DUMP_HDR_EN is undefined, have no HDR state, so that the first word is register 0 and the dump length is exactly REG_CNT+RAM_CNT words.

Verification
REQ-031 SHALL cover: defaults, out_ready tied to 1, with rf[i]=i*3 and ram[j]=32'hA000+j -> 48 words in order, out_last only on 32'hA00F, and done 1 cycle later.
REQ-032 SHALL cover: out_ready low for 5 cycles during word 7 -> out_valid and out_data stable for all 6 cycles, with no skipped or duplicated word.
REQ-033 SHALL cover: RAM_CNT=0 and REG_CNT=4 -> exactly 4 words, with out_last on regAddr=3 data.
REQ-034 SHALL cover: rst pulsed after the 10th transfer -> all outputs are 0 the next cycle, no done pulse, and a restart yields register 0 first.
REQ-035 SHALL cover: start pulsed while busy -> ignored, with word count unchanged at 48.
REQ-036 SHALL cover: SM_DBG_DUMP_HDR_EN defined -> first word 32'hD0D01020, followed by 48 data words.
